// File: rtl/color_bounce_pkg.sv
// Shared types, widths, reset constants and helpers for the Color Bounce step controller.
package color_bounce_pkg;

    localparam int BALL_W  = 8;
    localparam int PX_W    = 7;
    localparam int COL_W   = 3;
    localparam int NPLAT   = 4;
    localparam int SCORE_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DRAW,
        S_WAIT,
        S_MOVE,
        S_CHECK,
        S_OVER
    } state_t;

    localparam logic [COL_W-1:0] COL_BLUE  = 3'd1;
    localparam logic [COL_W-1:0] COL_GREEN = 3'd2;
    localparam logic [COL_W-1:0] COL_RED   = 3'd4;
    localparam logic [COL_W-1:0] COL_WHITE = 3'd7;

    localparam logic [COL_W-1:0]       RST_COLOR_BALL  = COL_RED;
    localparam logic [NPLAT*COL_W-1:0] RST_COLOR_PLATS = {3'd7, 3'd4, 3'd2, 3'd1};
    localparam logic [NPLAT*PX_W-1:0]  RST_POS_PLATS   = {7'd90, 7'd60, 7'd30, 7'd0};
    localparam logic [7:0]             LFSR_SEED       = 8'hA5;

    // Three-digit BCD increment that sticks at 999 instead of rolling over.
    function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        r = s;
        if (s != 12'h999) begin
            if (r[3:0] != 4'd9) begin
                r[3:0] = r[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (r[7:4] != 4'd9) begin
                    r[7:4] = r[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = r[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bounce_step_ctrl_if.sv
// Player/draw-FSM side of the step controller: control pulses in, game-state memory values out.
interface bounce_step_ctrl_if;

    logic                                                    start;
    logic                                                    frame_tick;
    logic [color_bounce_pkg::COL_W-1:0]                      color_sel;
    logic                                                    color_load;
    logic                                                    draw_ack;
    logic [color_bounce_pkg::BALL_W-1:0]                     prev_ball_out;
    logic [color_bounce_pkg::BALL_W-1:0]                     curr_ball_out;
    logic [color_bounce_pkg::COL_W-1:0]                      color_ball_out;
    logic [color_bounce_pkg::NPLAT*color_bounce_pkg::COL_W-1:0] color_plats_out;
    logic [color_bounce_pkg::NPLAT*color_bounce_pkg::PX_W-1:0]  position_plats_out;
    logic [color_bounce_pkg::SCORE_W-1:0]                    score_out;
    logic                                                    draw_req;
    logic                                                    game_over;
    logic                                                    busy;

    modport master (
        output start, frame_tick, color_sel, color_load, draw_ack,
        input  prev_ball_out, curr_ball_out, color_ball_out, color_plats_out,
               position_plats_out, score_out, draw_req, game_over, busy
    );

    modport slave (
        input  start, frame_tick, color_sel, color_load, draw_ack,
        output prev_ball_out, curr_ball_out, color_ball_out, color_plats_out,
               position_plats_out, score_out, draw_req, game_over, busy
    );

endinterface

// File: rtl/color_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying non-black colours for wrapped platforms.
module color_lfsr
    import color_bounce_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [COL_W-1:0] color
);

    logic [7:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    // Code 0 would draw an invisible platform, so it is remapped to white.
    assign color = (q[2:0] == 3'd0) ? COL_WHITE : q[2:0];

endmodule

// File: rtl/bounce_step_ctrl.sv
// Per-frame Color Bounce sequencer: ball/platform step, landing colour check, BCD score, redraw request.
module bounce_step_ctrl
    import color_bounce_pkg::*;
#(
    parameter logic [BALL_W-1:0] Y_TOP    = 8'd8,
    parameter logic [BALL_W-1:0] Y_FLOOR  = 8'd100,
    parameter logic [BALL_W-1:0] STEP     = 8'd4,
    parameter logic [PX_W-1:0]   BALL_X   = 7'd40,
    parameter logic [PX_W-1:0]   PLAT_W   = 7'd16,
    parameter logic [PX_W-1:0]   SCREEN_W = 7'd120
) (
    input  logic              clk,
    input  logic              reset,
    bounce_step_ctrl_if.slave bus
);

    localparam logic [BALL_W-1:0] BALL_X_W  = {1'b0, BALL_X};
    localparam logic [BALL_W-1:0] PLAT_SPAN = {1'b0, PLAT_W} - 8'd1;

    state_t                        state, state_n;
    logic [BALL_W-1:0]             prev_ball, curr_ball;
    logic                          dir_down, landed;
    logic [COL_W-1:0]              color_ball, color_pend, lfsr_color;
    logic [NPLAT-1:0][COL_W-1:0]   color_plats;
    logic [NPLAT-1:0][PX_W-1:0]    pos_plats;
    logic [SCORE_W-1:0]            score;
    logic                          draw_req, draw_req_n;
    logic                          hit, hit_match, lfsr_step;
    logic [COL_W-1:0]              hit_color;

    assign lfsr_step = (state == S_MOVE);

    color_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .color (lfsr_color)
    );

    // Lowest-index platform under the ball column wins; the span is not wrapped at the screen edge.
    always_comb begin
        hit       = 1'b0;
        hit_color = '0;
        for (int i = NPLAT - 1; i >= 0; i--) begin
            if (({1'b0, pos_plats[i]} <= BALL_X_W) &&
                (BALL_X_W <= ({1'b0, pos_plats[i]} + PLAT_SPAN))) begin
                hit       = 1'b1;
                hit_color = color_plats[i];
            end
        end
    end

    assign hit_match = hit && (hit_color == color_ball);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            draw_req <= 1'b0;
        end else begin
            state    <= state_n;
            draw_req <= draw_req_n;
        end
    end

    always_comb begin
        state_n    = state;
        draw_req_n = draw_req;
        case (state)
            S_IDLE: begin
                if (bus.start) state_n = S_INIT;
            end
            S_INIT: begin
                state_n    = S_DRAW;
                draw_req_n = 1'b1;
            end
            S_DRAW: begin
                if (bus.draw_ack) begin
                    state_n    = S_WAIT;
                    draw_req_n = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.frame_tick) state_n = S_MOVE;
            end
            S_MOVE: begin
                state_n = S_CHECK;
            end
            S_CHECK: begin
                state_n    = (!landed || hit_match) ? S_DRAW : S_OVER;
                draw_req_n = 1'b1;
            end
            S_OVER: begin
                // The losing frame is still drawn; its ack is the only one accepted here.
                if (bus.draw_ack) draw_req_n = 1'b0;
                if (bus.start) begin
                    state_n    = S_INIT;
                    draw_req_n = 1'b0;
                end
            end
            default: begin
                state_n    = S_IDLE;
                draw_req_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_INIT) begin
            prev_ball   <= Y_TOP;
            curr_ball   <= Y_TOP;
            dir_down    <= 1'b1;
            landed      <= 1'b0;
            color_ball  <= RST_COLOR_BALL;
            color_pend  <= RST_COLOR_BALL;
            color_plats <= RST_COLOR_PLATS;
            pos_plats   <= RST_POS_PLATS;
            score       <= '0;
        end else if (state == S_MOVE) begin
            prev_ball  <= curr_ball;
            color_ball <= bus.color_load ? bus.color_sel : color_pend;
            if (dir_down) begin
                if (curr_ball + STEP >= Y_FLOOR) begin
                    curr_ball <= Y_FLOOR;
                    dir_down  <= 1'b0;
                    landed    <= 1'b1;
                end else begin
                    curr_ball <= curr_ball + STEP;
                end
            end else if (curr_ball <= Y_TOP + STEP) begin
                curr_ball <= Y_TOP;
                dir_down  <= 1'b1;
            end else begin
                curr_ball <= curr_ball - STEP;
            end
            for (int i = 0; i < NPLAT; i++) begin
                if (pos_plats[i] == '0) begin
                    pos_plats[i]   <= SCREEN_W - 7'd1;
                    color_plats[i] <= lfsr_color;
                end else begin
                    pos_plats[i] <= pos_plats[i] - 7'd1;
                end
            end
        end else if (state == S_CHECK) begin
            landed <= 1'b0;
            if (landed && hit_match) score <= bcd_inc_sat(score);
        end
        // A colour load is honoured in every state, including the INIT reload.
        if (!reset && bus.color_load) color_pend <= bus.color_sel;
    end

    assign bus.prev_ball_out      = prev_ball;
    assign bus.curr_ball_out      = curr_ball;
    assign bus.color_ball_out     = color_ball;
    assign bus.color_plats_out    = color_plats;
    assign bus.position_plats_out = pos_plats;
    assign bus.score_out          = score;
    assign bus.draw_req           = draw_req;
    assign bus.game_over          = (state == S_OVER);
    assign bus.busy               = (state == S_INIT) || (state == S_DRAW) ||
                                    (state == S_MOVE) || (state == S_CHECK);

endmodule

// File: tb/tb_bounce_step_ctrl.sv
// Bench for bounce_step_ctrl: directed game scenarios, BCD table, randomized frames vs. a game-level model.
module tb_bounce_step_ctrl;
    import color_bounce_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bounce_step_ctrl_if bus ();

    bounce_step_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Game-level reference state
    int         m_prev, m_curr, m_cball, m_pend, m_score;
    bit         m_down, m_over;
    int         m_x[4];
    int         m_c[4];
    logic [7:0] m_lfsr;

    typedef struct {
        logic [11:0] in_v;
        logic [11:0] exp_v;
    } bcd_vec_t;

    typedef struct {
        int          tick;
        logic [7:0]  curr;
        logic [7:0]  prev;
        logic [11:0] score;
    } traj_vec_t;

    bcd_vec_t  bcd_tab[6];
    traj_vec_t traj_tab[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_init();
        m_prev  = 8;
        m_curr  = 8;
        m_down  = 1;
        m_cball = 4;
        m_pend  = 4;
        m_x     = '{0, 30, 60, 90};
        m_c     = '{1, 2, 4, 7};
        m_score = 0;
        m_over  = 0;
    endtask

    task automatic model_reset();
        model_init();
        m_lfsr = 8'hA5;
    endtask

    function automatic int lfsr_col();
        return (m_lfsr % 8 == 0) ? 7 : int'(m_lfsr % 8);
    endfunction

    task automatic model_step();
        bit landed;
        int hit;
        int col;
        landed = 0;
        m_prev = m_curr;
        if (m_down) begin
            if (m_curr + 4 >= 100) begin
                m_curr = 100; m_down = 0; landed = 1;
            end else m_curr += 4;
        end else begin
            if (m_curr <= 12) begin
                m_curr = 8; m_down = 1;
            end else m_curr -= 4;
        end
        col = lfsr_col();
        for (int i = 0; i < 4; i++) begin
            if (m_x[i] == 0) begin
                m_x[i] = 119; m_c[i] = col;
            end else m_x[i]--;
        end
        m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_cball = m_pend;
        if (landed) begin
            hit = -1;
            for (int i = 3; i >= 0; i--)
                if (m_x[i] <= 40 && 40 <= m_x[i] + 15) hit = i;
            if (hit >= 0 && m_c[hit] == m_cball) m_score = (m_score < 999) ? m_score + 1 : 999;
            else m_over = 1;
        end
    endtask

    // Colour of the platform the ball would be over after the next step.
    function automatic int predict_color();
        int col = lfsr_col();
        for (int i = 0; i < 4; i++) begin
            int xn = (m_x[i] == 0) ? 119 : m_x[i] - 1;
            int cn = (m_x[i] == 0) ? col : m_c[i];
            if (xn <= 40 && 40 <= xn + 15) return cn;
        end
        return int'($urandom_range(1, 7));
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [27:0] pack_x();
        logic [27:0] r = '0;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = 7'(m_x[i]);
        return r;
    endfunction

    function automatic logic [11:0] pack_c();
        logic [11:0] r = '0;
        for (int i = 0; i < 4; i++) r[3*i +: 3] = 3'(m_c[i]);
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":curr"}, 32'(bus.curr_ball_out), m_curr);
        check({tag, ":prev"}, 32'(bus.prev_ball_out), m_prev);
        check({tag, ":color_ball"}, 32'(bus.color_ball_out), m_cball);
        check({tag, ":color_plats"}, 32'(bus.color_plats_out), 32'(pack_c()));
        check({tag, ":pos_plats"}, 32'(bus.position_plats_out), 32'(pack_x()));
        check({tag, ":score"}, 32'(bus.score_out), 32'(to_bcd(m_score)));
        check({tag, ":game_over"}, 32'(bus.game_over), 32'(m_over));
    endtask

    task automatic wait_draw(input int lat0, input int exp_lat, input string tag);
        int lat = lat0;
        while (bus.draw_req !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":draw_req_rise"}, 32'(bus.draw_req), 1);
        check({tag, ":latency"}, lat, exp_lat);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.start = 0; bus.frame_tick = 0; bus.color_load = 0; bus.draw_ack = 0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check({tag, ":draw_req"}, 32'(bus.draw_req), 0);
        check({tag, ":busy"}, 32'(bus.busy), 0);
        check_all(tag);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check({tag, ":busy_init"}, 32'(bus.busy), 1);
        model_init();
        wait_draw(1, 2, tag);
        check_all(tag);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk); bus.draw_ack = 1'b1;
        @(negedge clk); bus.draw_ack = 1'b0;
        check({tag, ":draw_req_fall"}, 32'(bus.draw_req), 0);
        check({tag, ":busy"}, 32'(bus.busy), 0);
        check({tag, ":game_over"}, 32'(bus.game_over), 32'(m_over));
    endtask

    task automatic load_color(input logic [2:0] c);
        @(negedge clk); bus.color_load = 1'b1; bus.color_sel = c;
        @(negedge clk); bus.color_load = 1'b0;
        m_pend = int'(c);
    endtask

    task automatic do_tick(input bit move_load, input logic [2:0] c, input string tag);
        @(negedge clk); bus.frame_tick = 1'b1;
        @(negedge clk); bus.frame_tick = 1'b0;
        check({tag, ":draw_req_in_move"}, 32'(bus.draw_req), 0);
        if (move_load) begin
            bus.color_load = 1'b1; bus.color_sel = c; m_pend = int'(c);
        end
        @(negedge clk); bus.color_load = 1'b0;
        model_step();
        wait_draw(2, 3, tag);
        check_all(tag);
    endtask

    task automatic pulse_tick();
        @(negedge clk); bus.frame_tick = 1'b1;
        @(negedge clk); bus.frame_tick = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        int mode;
        reset = 1'b1;
        bus.start = 0; bus.frame_tick = 0; bus.color_sel = 0; bus.color_load = 0; bus.draw_ack = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset:draw_req", 32'(bus.draw_req), 0);
        check("reset:busy", 32'(bus.busy), 0);
        check_all("reset");

        bcd_tab[0] = '{12'h000, 12'h001};
        bcd_tab[1] = '{12'h009, 12'h010};
        bcd_tab[2] = '{12'h099, 12'h100};
        bcd_tab[3] = '{12'h198, 12'h199};
        bcd_tab[4] = '{12'h998, 12'h999};
        bcd_tab[5] = '{12'h999, 12'h999};
        for (int i = 0; i < 6; i++)
            check("bcd_inc_sat", 32'(bcd_inc_sat(bcd_tab[i].in_v)), 32'(bcd_tab[i].exp_v));

        // Start, ack, then land on platform 2 with its own colour
        do_start("init");
        do_ack("init_ack");
        traj_tab[0] = '{1, 8'd12, 8'd8, 12'h000};
        traj_tab[1] = '{22, 8'd96, 8'd92, 12'h000};
        traj_tab[2] = '{23, 8'd100, 8'd96, 12'h001};
        traj_tab[3] = '{24, 8'd96, 8'd100, 12'h001};
        load_color(3'd4);
        for (int t = 1; t <= 24; t++) begin
            do_tick(1'b0, 3'd0, "hit_run");
            for (int k = 0; k < 4; k++) begin
                if (traj_tab[k].tick == t) begin
                    check("traj:curr", 32'(bus.curr_ball_out), 32'(traj_tab[k].curr));
                    check("traj:prev", 32'(bus.prev_ball_out), 32'(traj_tab[k].prev));
                    check("traj:score", 32'(bus.score_out), 32'(traj_tab[k].score));
                end
            end
            if (t == 1) begin
                check("wrap:plat0_x", 32'(bus.position_plats_out[6:0]), 119);
                check("wrap:plat0_col", 32'(bus.color_plats_out[2:0]), 5);
            end
            if (t == 23) check("hit:plat2_x", 32'(bus.position_plats_out[20:14]), 37);
            do_ack("hit_ack");
        end

        // Same landing with a mismatching colour ends the game
        do_reset("reset2");
        do_start("init2");
        do_ack("init2_ack");
        load_color(3'd2);
        for (int t = 1; t <= 23; t++) begin
            do_tick(1'b0, 3'd0, "miss_run");
            if (t < 23) do_ack("miss_ack");
        end
        check("miss:game_over", 32'(bus.game_over), 1);
        check("miss:busy", 32'(bus.busy), 0);
        do_ack("over_ack");
        pulse_tick();
        repeat (3) @(negedge clk);
        check("over:tick_ignored_req", 32'(bus.draw_req), 0);
        check("over:tick_ignored_curr", 32'(bus.curr_ball_out), 100);
        check("over:still_over", 32'(bus.game_over), 1);
        do_start("restart");
        do_ack("restart_ack");

        // Tick during DRAW is dropped, then reset mid-draw
        do_tick(1'b0, 3'd0, "drop");
        pulse_tick();
        @(negedge clk);
        check("drop:draw_req", 32'(bus.draw_req), 1);
        check("drop:busy", 32'(bus.busy), 1);
        do_ack("drop_ack");
        repeat (3) @(negedge clk);
        check("drop:no_queue_req", 32'(bus.draw_req), 0);
        check("drop:no_queue_curr", 32'(bus.curr_ball_out), 32'(m_curr));
        do_tick(1'b0, 3'd0, "pre_reset");
        do_reset("reset_in_draw");

        // Randomized frames against the model
        do_start("rnd_init");
        do_ack("rnd_init_ack");
        for (int f = 0; f < 300; f++) begin
            if (m_over) begin
                if ($urandom_range(0, 1) == 1) begin
                    pulse_tick();
                    @(negedge clk);
                    check("rnd_over:req", 32'(bus.draw_req), 0);
                end
                do_start("rnd_restart");
                do_ack("rnd_restart_ack");
                continue;
            end
            c    = ($urandom_range(0, 3) != 0) ? 3'(predict_color()) : 3'($urandom_range(1, 7));
            mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); bus.start = 1'b1;
                @(negedge clk); bus.start = 1'b0;
                check("rnd:start_ignored", 32'(bus.busy), 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk); bus.draw_ack = 1'b1;
                @(negedge clk); bus.draw_ack = 1'b0;
            end
            if (mode == 1) load_color(c);
            do_tick(mode == 2, c, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                pulse_tick();
                check("rnd:stray_tick_req", 32'(bus.draw_req), 1);
                check("rnd:stray_tick_curr", 32'(bus.curr_ball_out), 32'(m_curr));
                check("rnd:stray_tick_busy", 32'(bus.busy), 32'(!m_over));
            end
            if ($urandom_range(0, 3) == 0) load_color(3'($urandom_range(1, 7)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rnd:req_held", 32'(bus.draw_req), 1);
            do_ack("rnd_ack");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
